// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//
// Groups every non-clock/reset signal of the instruction-fetch stage into one
// bundle.
//
// Signal summary:
//   stall          : hazard unit asks fetch to hold PC and IF/ID this cycle
//   branch_taken   : decode resolved a taken branch this cycle
//   branch_target  : redirect address (bit 0 ignored)
//   imem_addr      : instruction-memory address (always equals pc)
//   imem_data      : instruction word at imem_addr, returned the same cycle
//   pc             : current program counter
//   if_id_instr    : registered instruction handed to decode
//   if_id_pc_plus2 : registered PC+2 of that instruction
//   if_id_valid    : IF/ID holds a real instruction (0 = bubble)
//   fetch_halted   : fetch stage is frozen after fetching HLT
//
// Modports:
//   master : the fetch stage itself
//   slave  : its environment (hazard unit, decode, instruction memory)
// ---------------------------------------------------------------------------
interface fetch_stage_if;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        fetch_halted;

  modport master (
    input  stall, branch_taken, branch_target, imem_data,
    output imem_addr, pc, if_id_instr, if_id_pc_plus2, if_id_valid,
           fetch_halted
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_data,
    input  imem_addr, pc, if_id_instr, if_id_pc_plus2, if_id_valid,
           fetch_halted
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the 16-bit pipelined CPU. Owns the program
// counter, presents it to instruction memory, and registers the returned
// word together with its PC+2 into the IF/ID pipeline register. Handles
// stall and branch-redirect requests and freezes after fetching HLT until a
// taken branch releases it.
//
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fetch_stage_if.master (stall/branch inputs, imem bus, IF/ID
//           outputs, pc and fetch_halted status)
//
// Parameters:
//   RESET_PC   : PC value loaded on reset
//   NOP_INSTR  : instruction word written into IF/ID for bubbles
//   HLT_OPCODE : instr[15:12] value that identifies HLT
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;
  logic        valid_q, valid_d;

  logic [15:0] pc_plus2;
  logic        is_hlt;

  // Bit 0 of the branch target is deliberately dropped to keep pc halfword
  // aligned; this sink keeps that intent visible.
  logic unused_target_lsb;
  assign unused_target_lsb = bus.branch_target[0];

  // Wraps naturally at 16 bits (16'hFFFE + 2 = 16'h0000).
  assign pc_plus2 = pc_q + 16'd2;
  assign is_hlt   = (state_q == RUN) && (bus.imem_data[15:12] == HLT_OPCODE);

  // Next-state selection. The priority order matters: a taken branch must
  // flush the wrong-path word and leave HALT even when stall is raised in
  // the same cycle; stall then freezes everything, including a HALT bubble.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;

    if (bus.branch_taken) begin
      pc_d       = {bus.branch_target[15:1], 1'b0};
      instr_d    = NOP_INSTR;
      pc_plus2_d = 16'h0000;
      valid_d    = 1'b0;
      state_d    = RUN;
    end else if (bus.stall) begin
      // hold everything
    end else if (state_q == HALT) begin
      instr_d    = NOP_INSTR;
      pc_plus2_d = 16'h0000;
      valid_d    = 1'b0;
    end else if (is_hlt) begin
      // HLT itself goes to decode, but pc stays on the HLT address.
      instr_d    = bus.imem_data;
      pc_plus2_d = pc_plus2;
      valid_d    = 1'b1;
      state_d    = HALT;
    end else begin
      pc_d       = pc_plus2;
      instr_d    = bus.imem_data;
      pc_plus2_d = pc_plus2;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= {RESET_PC[15:1], 1'b0};
      instr_q    <= NOP_INSTR;
      pc_plus2_q <= 16'h0000;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.pc             = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc_plus2 = pc_plus2_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.fetch_halted   = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed testbench for fetch_stage. Instruction memory is modelled as a
// function of the address: word = {4'h1, addr[11:0]}, except that when
// hlt_en is set the word at hlt_addr reads as HLT (16'hF000).
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic clk;
  logic rst_n;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC   (16'h0000),
    .NOP_INSTR  (16'h0000),
    .HLT_OPCODE (4'hF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model.
  logic        hlt_en;
  logic [15:0] hlt_addr;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (hlt_en && a == hlt_addr) return 16'hF000;
    return {4'h1, a[11:0]};
  endfunction

  always_comb bus.imem_data = mem_word(bus.imem_addr);

  // One table row: inputs for the cycle, then expected state after the edge.
  typedef struct {
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic        hlt;
    logic [15:0] exp_pc;
    logic [15:0] exp_instr;
    logic [15:0] exp_pp2;
    logic        exp_valid;
    logic        exp_halted;
  } vector_t;

  vector_t vecs[$];
  int      tests_run;
  int      tests_failed;

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic b,
                               input logic [15:0] t, input logic h);
    bus.stall         = s;
    bus.branch_taken  = b;
    bus.branch_target = t;
    hlt_en            = h;
  endtask

  // Checks everything visible after an edge; bubble rows skip pc_plus2
  // (its content is meaningless when valid is low).
  task automatic checkAll(input string tag, input vector_t v);
    checkOutput({tag, " pc"},        bus.pc,                 v.exp_pc);
    checkOutput({tag, " imem_addr"}, bus.imem_addr,          v.exp_pc);
    checkOutput({tag, " valid"},     {15'd0, bus.if_id_valid}, {15'd0, v.exp_valid});
    checkOutput({tag, " halted"},    {15'd0, bus.fetch_halted}, {15'd0, v.exp_halted});
    checkOutput({tag, " instr"},     bus.if_id_instr,        v.exp_instr);
    if (v.exp_valid)
      checkOutput({tag, " pc_plus2"}, bus.if_id_pc_plus2, v.exp_pp2);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " pc"},       bus.pc,             16'h0000);
    checkOutput({tag, " instr"},    bus.if_id_instr,    16'h0000);
    checkOutput({tag, " pc_plus2"}, bus.if_id_pc_plus2, 16'h0000);
    checkOutput({tag, " valid"},    {15'd0, bus.if_id_valid},  16'h0000);
    checkOutput({tag, " halted"},   {15'd0, bus.fetch_halted}, 16'h0000);
  endtask

  initial begin
    vector_t hv;
    tests_run    = 0;
    tests_failed = 0;
    hlt_addr     = 16'h0006;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    rst_n = 1'b0;

    //          stall br  tgt        hlt  pc         instr      pp2        v  h
    // straight line from reset
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,16'h0002,16'h1000,16'h0002,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,16'h0004,16'h1002,16'h0004,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,16'h0006,16'h1004,16'h0006,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,16'h0008,16'h1006,16'h0008,1'b1,1'b0});
    // two stall cycles at pc 8
    vecs.push_back('{1'b1,1'b0,16'h0000,1'b0,16'h0008,16'h1006,16'h0008,1'b1,1'b0});
    vecs.push_back('{1'b1,1'b0,16'h0000,1'b0,16'h0008,16'h1006,16'h0008,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,16'h000A,16'h1008,16'h000A,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,16'h000C,16'h100A,16'h000C,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,16'h000E,16'h100C,16'h000E,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,16'h0010,16'h100E,16'h0010,1'b1,1'b0});
    // branch to 0x0041 (lsb dropped) with simultaneous stall
    vecs.push_back('{1'b1,1'b1,16'h0041,1'b0,16'h0040,16'h0000,16'h0000,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,16'h0042,16'h1040,16'h0042,1'b1,1'b0});
    // go back to 4, then hit HLT at 6
    vecs.push_back('{1'b0,1'b1,16'h0004,1'b1,16'h0004,16'h0000,16'h0000,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b1,16'h0006,16'h1004,16'h0006,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b1,16'h0006,16'hF000,16'h0008,1'b1,1'b1});
    for (int k = 0; k < 5; k++)
      vecs.push_back('{1'b0,1'b0,16'h0000,1'b1,16'h0006,16'h0000,16'h0000,1'b0,1'b1});
    // stall while halted holds, then branch releases HALT
    vecs.push_back('{1'b1,1'b0,16'h0000,1'b1,16'h0006,16'h0000,16'h0000,1'b0,1'b1});
    vecs.push_back('{1'b0,1'b1,16'h0020,1'b1,16'h0020,16'h0000,16'h0000,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,16'h0022,16'h1020,16'h0022,1'b1,1'b0});
    // wrap at the top of the address space
    vecs.push_back('{1'b0,1'b1,16'hFFFF,1'b0,16'hFFFE,16'h0000,16'h0000,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h1FFE,16'h0000,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,16'h0002,16'h1000,16'h0002,1'b1,1'b0});

    #1;
    checkReset("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].hlt);
      @(posedge clk);
      #1;
      checkAll($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
    end

    // Halt at 0x0030, then drop reset between edges.
    hlt_addr = 16'h0030;
    applyStimulus(1'b0, 1'b1, 16'h0030, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    @(posedge clk);
    #1;
    hv = '{1'b0,1'b0,16'h0000,1'b1,16'h0030,16'hF000,16'h0032,1'b1,1'b1};
    checkAll("halt30", hv);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkReset("async_reset");
    @(negedge clk);
    hlt_en = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;
    hv = '{1'b0,1'b0,16'h0000,1'b0,16'h0002,16'h1000,16'h0002,1'b1,1'b0};
    checkAll("after_reset", hv);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
